// File: rtl/hires_pkg.sv
// rtl/hires_pkg.sv - shared types, constants and line-address helper for hires_fetch
package hires_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_RESYNC, ST_FILL} state_t;
  typedef enum logic [1:0] {F_CUR_ISSUE, F_CUR_WAIT, F_NXT_ISSUE, F_NXT_WAIT} fill_t;

  localparam int          H_PIX_DEF  = 280;
  localparam int          V_PIX_DEF  = 192;
  localparam logic [15:0] PAGE1_BASE = 16'h2000;
  localparam logic [15:0] PAGE2_BASE = 16'h4000;
  localparam logic [15:0] ADR_END    = 16'd53760;

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] RGB_VIOLET = 24'hFF44FD;
  localparam logic [23:0] RGB_GREEN  = 24'h14F53C;
  localparam logic [23:0] RGB_BLUE   = 24'h14CFFD;
  localparam logic [23:0] RGB_ORANGE = 24'hFF6A3C;

  // Apple II interleave: y[2:0] strides 1K, y[5:3] strides 128 bytes, y[7:6] strides 40 bytes.
  function automatic logic [15:0] line_base(input logic pg, input logic [7:0] y);
    logic [15:0] third;
    third = {14'd0, y[7:6]} * 16'd40;
    return (pg ? PAGE2_BASE : PAGE1_BASE) + {3'd0, y[2:0], 10'd0} + {6'd0, y[5:3], 7'd0} + third;
  endfunction

endpackage

// File: rtl/hires_div280.sv
// rtl/hires_div280.sv - sequential restoring divider: adr -> y, x, then x -> col, bitn (14 steps)
module hires_div280
  import hires_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] adr,
  output logic        done,
  output logic [7:0]  y,
  output logic [8:0]  x,
  output logic [5:0]  col,
  output logic [2:0]  bitn
);

  logic [16:0] rem;
  logic [16:0] rem_nxt;
  logic [16:0] divisor;
  logic [3:0]  step;
  logic        busy;
  logic        ge;

  // Steps 0..7 divide by H_PIX (quotient y), steps 8..13 divide the remainder by 7.
  always_comb begin
    if (step < 4'd8) divisor = 17'(H_PIX) << (4'd7 - step);
    else             divisor = 17'd7 << (4'd13 - step);
    ge      = (rem >= divisor);
    rem_nxt = ge ? rem - divisor : rem;
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      step <= 4'd0;
      rem  <= 17'd0;
      y    <= 8'd0;
      x    <= 9'd0;
      col  <= 6'd0;
      bitn <= 3'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        step <= 4'd0;
        rem  <= {1'b0, adr};
        y    <= 8'd0;
        col  <= 6'd0;
      end else if (busy) begin
        rem  <= rem_nxt;
        step <= step + 4'd1;
        if (step < 4'd8) y <= {y[6:0], ge};
        else             col <= {col[4:0], ge};
        if (step == 4'd7) x <= rem_nxt[8:0];
        if (step == 4'd13) begin
          bitn <= rem_nxt[2:0];
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hires_fetch.sv
// rtl/hires_fetch.sv - hi-res byte fetch, prefetch and pixel decode feeding the VGA timing stage
module hires_fetch
  import hires_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_PIX   = V_PIX_DEF,
  parameter int ACK_MAX = 24
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic [15:0] adr,
  output logic [23:0] d,
  input  logic        page2,
  input  logic        mono,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        underrun
);

  localparam logic [15:0] ADR_LIMIT = 16'(H_PIX * V_PIX);
  localparam logic [8:0]  X_LAST    = 9'(H_PIX - 1);
  localparam logic [5:0]  LAST_COL  = 6'(H_PIX / 7 - 1);
  localparam logic [7:0]  ACK_LAST  = 8'(ACK_MAX - 1);

  state_t      state;
  fill_t       fill;
  logic [15:0] adr_q;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [5:0]  col;
  logic [2:0]  bitn;
  logic [7:0]  cur_byte;
  logic [7:0]  nxt_byte;
  logic        nxt_valid;
  logic        prev_pix;
  logic        pg_sel;
  logic        oor;
  logic [7:0]  ack_cnt;
  logic        req_dst;

  logic        is_zero, in_range, changed, seq_step, restart, div_start, mem_done;
  logic        div_done;
  logic [7:0]  div_y;
  logic [8:0]  div_x;
  logic [5:0]  div_col;
  logic [2:0]  div_bitn;
  logic        pix, right_pix;
  logic [23:0] rgb;

  assign is_zero   = (adr == 16'd0);
  assign in_range  = (adr < ADR_LIMIT);
  assign changed   = (adr != adr_q);
  assign seq_step  = changed && !is_zero && (adr == adr_q + 16'd1) && (state == ST_RUN);
  assign restart   = changed && !seq_step;
  assign div_start = restart && !is_zero && in_range;
  assign mem_done  = mem_req && (mem_ack || ack_cnt == ACK_LAST);

  hires_div280 #(.H_PIX(H_PIX)) u_div (
    .clock_50 (clock_50),
    .reset    (reset),
    .start    (div_start),
    .adr      (adr),
    .done     (div_done),
    .y        (div_y),
    .x        (div_x),
    .col      (div_col),
    .bitn     (div_bitn)
  );

  always_comb begin
    pix       = cur_byte[bitn];
    right_pix = (bitn == 3'd6) ? (nxt_byte[0] && col != LAST_COL) : cur_byte[bitn + 3'd1];
    if (mono)                        rgb = pix ? RGB_WHITE : RGB_BLACK;
    else if (!pix)                   rgb = RGB_BLACK;
    else if (prev_pix || right_pix)  rgb = RGB_WHITE;
    else if (!cur_byte[7])           rgb = x[0] ? RGB_GREEN : RGB_VIOLET;
    else                             rgb = x[0] ? RGB_ORANGE : RGB_BLUE;
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      adr_q     <= 16'd0;
      state     <= ST_FILL;
      fill      <= F_CUR_ISSUE;
      x         <= 9'd0;
      y         <= 8'd0;
      col       <= 6'd0;
      bitn      <= 3'd0;
      cur_byte  <= 8'd0;
      nxt_byte  <= 8'd0;
      nxt_valid <= 1'b0;
      prev_pix  <= 1'b0;
      pg_sel    <= 1'b0;
      oor       <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 16'd0;
      ack_cnt   <= 8'd0;
      req_dst   <= 1'b0;
      underrun  <= 1'b0;
      d         <= RGB_BLACK;
    end else begin
      adr_q <= adr;
      d     <= (state == ST_RUN && !oor) ? rgb : RGB_BLACK;

      if (mem_req) begin
        if (mem_done) begin
          mem_req <= 1'b0;
          if (!mem_ack) underrun <= 1'b1;
          else if (!restart) begin
            if (req_dst) begin
              nxt_byte  <= mem_data;
              nxt_valid <= 1'b1;
            end else begin
              cur_byte <= mem_data;
            end
          end
        end else begin
          ack_cnt <= ack_cnt + 8'd1;
        end
      end

      case (state)
        ST_RESYNC: if (div_done) begin
          x        <= div_x;
          y        <= div_y;
          col      <= div_col;
          bitn     <= div_bitn;
          prev_pix <= 1'b0;
          state    <= ST_FILL;
          fill     <= F_CUR_ISSUE;
        end
        ST_FILL: begin
          case (fill)
            F_CUR_ISSUE: if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= line_base(pg_sel, y) + {10'd0, col};
              ack_cnt  <= 8'd0;
              req_dst  <= 1'b0;
              fill     <= F_CUR_WAIT;
            end
            F_CUR_WAIT: if (mem_done) begin
              if (col == LAST_COL) state <= ST_RUN;
              else                 fill  <= F_NXT_ISSUE;
            end
            F_NXT_ISSUE: if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= line_base(pg_sel, y) + {10'd0, col + 6'd1};
              ack_cnt  <= 8'd0;
              req_dst  <= 1'b1;
              fill     <= F_NXT_WAIT;
            end
            default: if (mem_done) state <= ST_RUN;
          endcase
        end
        ST_RUN: ;
        default: state <= ST_FILL;
      endcase

      if (restart) begin
        mem_req   <= 1'b0;
        nxt_valid <= 1'b0;
        prev_pix  <= 1'b0;
        oor       <= !in_range;
        if (is_zero) begin
          x      <= 9'd0;
          y      <= 8'd0;
          col    <= 6'd0;
          bitn   <= 3'd0;
          pg_sel <= page2;
          state  <= ST_FILL;
          fill   <= F_CUR_ISSUE;
        end else if (in_range) begin
          state <= ST_RESYNC;
        end else begin
          state <= ST_RUN;
        end
      end else if (seq_step) begin
        oor      <= !in_range;
        prev_pix <= pix;
        if (x == X_LAST) begin
          // Sequential wrap to a new line refills during blanking rather than counting as underrun.
          x        <= 9'd0;
          col      <= 6'd0;
          bitn     <= 3'd0;
          y        <= y + 8'd1;
          prev_pix <= 1'b0;
          if (in_range) begin
            mem_req   <= 1'b0;
            nxt_valid <= 1'b0;
            state     <= ST_FILL;
            fill      <= F_CUR_ISSUE;
          end
        end else if (bitn == 3'd6) begin
          x    <= x + 9'd1;
          bitn <= 3'd0;
          col  <= col + 6'd1;
          if (in_range) begin
            if (nxt_valid) cur_byte <= nxt_byte;
            else           underrun <= 1'b1;
            nxt_valid <= 1'b0;
            if (col + 6'd1 != LAST_COL && !mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= line_base(pg_sel, y) + {10'd0, col + 6'd2};
              ack_cnt  <= 8'd0;
              req_dst  <= 1'b1;
            end
          end
        end else begin
          x    <= x + 9'd1;
          bitn <= bitn + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hires_fetch.sv
// tb/tb_hires_fetch.sv - directed self-checking bench for hires_fetch
module tb_hires_fetch;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] adr = 16'd0;
  logic [23:0] d;
  logic        page2 = 1'b0;
  logic        mono = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic        underrun;

  logic [7:0]  mem [0:65535];
  logic [15:0] ack_log [$];
  int          lat = 2;
  bit          ack_en = 1'b1;
  int          wcnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc;
  int          n;

  always #10 clock_50 = ~clock_50;

  hires_fetch dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .adr      (adr),
    .d        (d),
    .page2    (page2),
    .mono     (mono),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .underrun (underrun)
  );

  // Memory model: acks a held request after lat idle cycles, one-cycle pulse.
  initial begin
    forever begin
      @(negedge clock_50);
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        if (wcnt >= lat) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          ack_log.push_back(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] logged(input int i);
    return (i < ack_log.size()) ? ack_log[i] : 16'hFFFF;
  endfunction

  task automatic wait_acks(input string tag, input int cnt, input int bound);
    for (int i = 0; i < bound && ack_log.size() < cnt; i++) @(negedge clock_50);
    check(tag, ack_log.size(), cnt);
  endtask

  task automatic goto_zero();
    @(negedge clock_50);
    adr = 16'd100;
    repeat (4) @(negedge clock_50);
    ack_log.delete();
    adr = 16'd0;
    wait_acks("fill_acks", 2, 120);
    repeat (3) @(negedge clock_50);
  endtask

  task automatic wait_req_high(input string tag);
    for (int i = 0; i < 40 && !mem_req; i++) @(negedge clock_50);
    check(tag, mem_req, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'h81;
    mono = 1'b1;
    repeat (3) @(negedge clock_50);
    check("rst_d", d, 24'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_underrun", underrun, 1'b0);

    reset = 1'b1;
    wait_acks("boot_acks", 2, 100);
    check("boot_addr0", logged(0), 16'h2000);
    check("boot_addr1", logged(1), 16'h2001);
    check("boot_underrun", underrun, 1'b0);
    repeat (3) @(negedge clock_50);
    check("mono_x0", d, 24'hFFFFFF);
    adr = 16'd1;
    repeat (2) @(negedge clock_50);
    check("mono_x1", d, 24'h000000);
    repeat (2) @(negedge clock_50);

    mono = 1'b0;
    mem[16'h2000] = 8'h01;
    goto_zero();
    check("violet_x0", d, 24'hFF44FD);

    mem[16'h2000] = 8'h03;
    goto_zero();
    check("white_x0", d, 24'hFFFFFF);
    adr = 16'd1;
    repeat (2) @(negedge clock_50);
    check("white_x1", d, 24'hFFFFFF);
    repeat (2) @(negedge clock_50);

    mem[16'h2000] = 8'h82;
    goto_zero();
    check("pal1_x0_black", d, 24'h000000);
    adr = 16'd1;
    repeat (2) @(negedge clock_50);
    check("orange_x1", d, 24'hFF6A3C);
    repeat (2) @(negedge clock_50);

    mono = 1'b1;
    mem[16'h2400] = 8'h7F;
    adr = 16'd559;
    repeat (80) @(negedge clock_50);
    ack_log.delete();
    adr = 16'd280;
    cyc = 0;
    while (ack_log.size() < 2 && cyc < 200) begin
      @(negedge clock_50);
      cyc++;
    end
    check("dbl_addr0", logged(0), 16'h2400);
    check("dbl_addr1", logged(1), 16'h2401);
    check("dbl_in_time", (cyc <= 66), 1'b1);
    repeat (3) @(negedge clock_50);
    check("dbl_pix", d, 24'hFFFFFF);

    ack_log.delete();
    adr = 16'd17920;
    wait_acks("row64_acks", 1, 100);
    check("row64_addr", logged(0), 16'h2028);
    repeat (30) @(negedge clock_50);

    page2 = 1'b1;
    goto_zero();
    check("page2_addr", logged(0), 16'h4000);
    page2 = 1'b0;

    ack_log.delete();
    adr = 16'd54000;
    repeat (40) @(negedge clock_50);
    check("oor_no_fetch", ack_log.size(), 0);
    check("oor_d", d, 24'h0);
    check("oor_mem_req", mem_req, 1'b0);
    check("pre_slow_underrun", underrun, 1'b0);

    ack_en = 1'b0;
    adr = 16'd100;
    repeat (4) @(negedge clock_50);
    adr = 16'd0;
    wait_req_high("slow_req_rise");
    n = 0;
    while (mem_req && n < 100) begin
      n++;
      @(negedge clock_50);
    end
    check("slow_req_len", n, 24);
    check("slow_underrun", underrun, 1'b1);
    ack_en = 1'b1;
    repeat (40) @(negedge clock_50);
    check("underrun_sticky", underrun, 1'b1);

    ack_en = 1'b0;
    adr = 16'd100;
    repeat (4) @(negedge clock_50);
    adr = 16'd0;
    wait_req_high("rst_req_rise");
    reset = 1'b0;
    @(negedge clock_50);
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_clr_underrun", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
